instr_fetch_queue: RTL
======================

# instr_fetch_queue

Parametrised successor to the single-word instruction register: a DEPTH-entry prefetch queue that accepts instruction words from fetch with a valid/ready handshake, followed by a registered issue stage that holds the current instruction and presents its decoded fields to the control unit. It sits between instruction memory and the control FSM. It supports a branch flush and back-pressure from the control unit. It presents Op, r1, r2, LMC, CC and the three 16-bit-style immediates, generalised to any field width.

## Interface
Parameters:
- OP_W, 4, opcode field width.
- REG_W, 4, register-specifier width.
- DEPTH, 4, prefetch queue entries; power of two, ≥2.
- Derived localparams, not overridable:
  - IMM_W = REG_W+4.
  - IW = OP_W+2*REG_W+4.
  - XW = 2*IMM_W.

Ports:
- CLK, in, 1: single clock. All state changes on the rising edge.
- Reset, in, 1: asynchronous, active-high.
- fetch_valid, in, 1: fetch_data is valid this cycle.
- fetch_data, in, IW: instruction word.
- fetch_ready, out, 1: queue can accept a word. Equals !full.
- flush, in, 1: discard all queued and issued instructions. Used on branch taken.
- issue_ready, in, 1: control unit consumes the current instruction this cycle.
- ir_valid, out, 1: issue register holds a valid instruction.
- Op, out, OP_W: instr[IW-1 -: OP_W].
- r1, out, REG_W: next REG_W bits below Op.
- r2, out, REG_W: next REG_W bits below r1.
- LMC, out, 1: instr[3].
- CC, out, 3: instr[2:0].
- signE, out, XW: imm = instr[IMM_W-1:0], sign-extended to XW.
- zeroE, out, XW: imm zero-extended to XW.
- upper, out, XW: {imm, IMM_W'b0}.
- count, out, $clog2(DEPTH+1): number of queued words. Excludes the issue register.

## Operation
**Handshakes**
- Push when fetch_valid && fetch_ready.
- Issue-consume when ir_valid && issue_ready.

**IR load rule**
- IR loads the queue head when queue non-empty && (!ir_valid || issue_ready).
- A consumed IR with an empty queue clears ir_valid.

**No bypass**
- A pushed word always passes through the queue.
- A word may be popped into the IR in the same cycle another word is pushed.

**fetch_ready**
- fetch_ready depends on count only; there is no combinational path from issue_ready.
- A full queue refuses a push even in a cycle where it pops.

**flush**
- Synchronous. Takes priority over everything else.
- On the next edge: count=0, ir_valid=0, pointers reset.
- A push presented in the flush cycle is dropped, and fetch_ready is not gated by flush.

**Decoded outputs**
- Combinational slices of the IR register.
- When ir_valid=0 the IR contents are zero, so every field reads 0.

**Reset**
- Asynchronous. All outputs and state go to 0: count=0, ir_valid=0, IR=0, pointers=0.
- fetch_ready reads 1 while not full, i.e. 1 immediately after reset.
- The queue storage array does not need reset.

**Pointers**
- log2(DEPTH) bits, natural wrap.
- Full/empty is resolved by count, not by pointer compare.

## Timing
- Push at edge N: word visible at the queue head after edge N. Earliest IR load is edge N+1, and decoded fields are valid after N+1. Fetch-to-decode latency is 2 cycles.
- Back-to-back issue: with the queue non-empty and issue_ready=1 every cycle, one instruction issues per cycle.
- Simultaneous push and pop: count is unchanged.
  - At count=DEPTH, the push is refused, so count drops by 1.
- Flush and push in the same cycle: queue empty after the edge; the pushed word is lost.
- Flush and issue in the same cycle: the consume is honoured by the control unit, but the IR is still cleared.
- Reset asserted mid-operation clears state immediately, without waiting for CLK.

## Structure
- Shared package cpu_pkg holds:
  - OP_W and REG_W defaults.
  - Field-offset localparams: OP_LSB, R1_LSB, R2_LSB, LMC_BIT, CC_LSB.
  - Opcode constants used by the control unit.
- One sub-module, instr_fifo: parametrised storage, pointers and count, with push/pop/flush inputs.
- The top level owns the IR register, the load rule and the field/immediate extraction.

## Test plan
- Reset released, no activity: count=0, ir_valid=0, all fields 0, fetch_ready=1.
- Push 16'hA3F9, issue_ready=0. After 2 edges: ir_valid=1, Op=4'hA, r1=3, r2=4'hF, LMC=1, CC=3'b001.
  - signE=16'hFFF9, zeroE=16'h00F9, upper=16'hF900.
- Push 5 words with issue_ready=0 and DEPTH=4:
  - the first word lands in the IR;
  - the next 4 fill the queue (count=4, fetch_ready=0);
  - a 6th push is refused.
  - Then issue_ready=1: words issue in order, one per cycle.
- Full queue, fetch_valid=1 and issue_ready=1 held: the push is refused in full cycles, accepted once count<4. No word is lost or duplicated across 10 words.
- Queue holding 3 words plus a valid IR, flush=1 with a simultaneous push: next edge count=0, ir_valid=0, and the pushed word never issues.
- Reset asserted asynchronously mid-stream, between edges: outputs go to 0 before the next edge, and the first instruction issued after release is a fresh push.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default field widths, instruction field offsets and
// the opcode constants decoded by the control unit.
package cpu_pkg;

   localparam int OP_W_DEF  = 4;
   localparam int REG_W_DEF = 4;

   // Word layout, MSB first: Op | r1 | r2 | LMC | CC (offsets at default widths).
   localparam int OP_LSB  = 2*REG_W_DEF + 4;
   localparam int R1_LSB  = REG_W_DEF + 4;
   localparam int R2_LSB  = 4;
   localparam int LMC_BIT = 3;
   localparam int CC_LSB  = 0;

   typedef enum logic [OP_W_DEF-1:0] {
      OP_NOP = 4'h0,
      OP_ADD = 4'h1,
      OP_SUB = 4'h2,
      OP_AND = 4'h3,
      OP_OR  = 4'h4,
      OP_LD  = 4'h5,
      OP_ST  = 4'h6,
      OP_LDI = 4'h7,
      OP_LUI = 4'h8,
      OP_BR  = 4'h9,
      OP_JMP = 4'hA
   } opcode_t;

endpackage

// File: rtl/instr_fifo.sv
// Prefetch queue storage: circular buffer whose full/empty state is tracked by
// an occupancy count rather than by pointer comparison.
module instr_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 4,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH+1)
) (
   input  logic          CLK,
   input  logic          Reset,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (push_ok && !flush) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/instr_fetch_queue.sv
// Prefetch queue followed by a registered issue stage; exposes the decoded
// fields and extended immediates of the instruction currently held for issue.
module instr_fetch_queue
   import cpu_pkg::*;
#(
   parameter int OP_W   = OP_W_DEF,
   parameter int REG_W  = REG_W_DEF,
   parameter int DEPTH  = 4,
   localparam int IMM_W = REG_W + 4,
   localparam int IW    = OP_W + 2*REG_W + 4,
   localparam int XW    = 2*IMM_W,
   localparam int CW    = $clog2(DEPTH+1)
) (
   input  logic          CLK,
   input  logic          Reset,
   input  logic          fetch_valid,
   input  logic [IW-1:0] fetch_data,
   output logic          fetch_ready,
   input  logic          flush,
   input  logic          issue_ready,
   output logic          ir_valid,
   output logic [OP_W-1:0]  Op,
   output logic [REG_W-1:0] r1,
   output logic [REG_W-1:0] r2,
   output logic          LMC,
   output logic [2:0]    CC,
   output logic [XW-1:0] signE,
   output logic [XW-1:0] zeroE,
   output logic [XW-1:0] upper,
   output logic [CW-1:0] count
);

   localparam int OP_SH = 2*REG_W + 4;
   localparam int R1_SH = REG_W + 4;

   function automatic logic [XW-1:0] sign_ext(input logic signed [IMM_W-1:0] imm);
      logic signed [XW-1:0] ext;
      ext = imm;
      return ext;
   endfunction

   function automatic logic [XW-1:0] zero_ext(input logic [IMM_W-1:0] imm);
      return {{(XW-IMM_W){1'b0}}, imm};
   endfunction

   logic [IW-1:0] head_p0;
   logic          full_p0;
   logic          empty_p0;
   logic          push_p0;
   logic          load_p0;
   logic [IW-1:0] ir_p1;
   logic          vld_p1;
   logic [IMM_W-1:0] imm_p1;

   // Stage 0: prefetch queue
   assign fetch_ready = !full_p0;
   assign push_p0     = fetch_valid && !full_p0;
   assign load_p0     = !empty_p0 && (!vld_p1 || issue_ready);

   instr_fifo #(
      .W     (IW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .CLK   (CLK),
      .Reset (Reset),
      .push  (push_p0),
      .pop   (load_p0),
      .flush (flush),
      .wdata (fetch_data),
      .rdata (head_p0),
      .count (count),
      .full  (full_p0),
      .empty (empty_p0)
   );

   // Stage 1: issue register; contents forced to zero whenever it is empty
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         ir_p1  <= '0;
         vld_p1 <= 1'b0;
      end else if (flush) begin
         ir_p1  <= '0;
         vld_p1 <= 1'b0;
      end else if (load_p0) begin
         ir_p1  <= head_p0;
         vld_p1 <= 1'b1;
      end else if (vld_p1 && issue_ready) begin
         ir_p1  <= '0;
         vld_p1 <= 1'b0;
      end
   end

   assign ir_valid = vld_p1;
   assign Op       = ir_p1[OP_SH +: OP_W];
   assign r1       = ir_p1[R1_SH +: REG_W];
   assign r2       = ir_p1[R2_LSB +: REG_W];
   assign LMC      = ir_p1[LMC_BIT];
   assign CC       = ir_p1[CC_LSB +: 3];
   assign imm_p1   = ir_p1[IMM_W-1:0];
   assign signE    = sign_ext(imm_p1);
   assign zeroE    = zero_ext(imm_p1);
   assign upper    = {imm_p1, {IMM_W{1'b0}}};

endmodule
